coreriscv_axi4_refill_collector: RTL

Collects the TileLink refill beats that leave the grant finish stage and assembles them into one complete 512-bit cache line (8 beats × 64 bits). It then presents the line, plus the transaction identifiers, to the cache data-array writer on a single valid/ready handshake. Single-beat acknowledgement grants (no data) pass through as a one-entry "ack" line with `io_line_has_data` = 0. The block sits directly downstream of the finish unit's `io_refill` port and exerts backpressure on it through `io_refill_ready`.

---
 rtl/coreriscv_axi4_refill_collector_if.sv | 68 ++++++
 rtl/coreriscv_axi4_refill_collector.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/coreriscv_axi4_refill_collector_if.sv
// rtl/coreriscv_axi4_refill_collector_if.sv - refill beat input and assembled line output bundle
//
// Purpose: groups the refill beat handshake (from the grant finish unit) and
// the assembled line handshake (to the cache data-array writer).
// Modports:
//   slave  - the collector: consumes refill beats, produces lines.
//   master - the surrounding environment: offers beats, takes lines.
// Signals:
//   io_refill_valid/ready, io_refill_bits_*  refill beat handshake and payload
//   io_line_valid/ready, io_line_*           assembled line handshake and payload
//   io_busy                                  multibeat line partially filled
//   io_error                                 sticky beat-order error
interface coreriscv_axi4_refill_collector_if;
  logic         io_refill_valid;
  logic         io_refill_ready;
  logic [2:0]   io_refill_bits_addr_beat;
  logic         io_refill_bits_client_xact_id;
  logic [1:0]   io_refill_bits_manager_xact_id;
  logic         io_refill_bits_is_builtin_type;
  logic [3:0]   io_refill_bits_g_type;
  logic [63:0]  io_refill_bits_data;
  logic         io_line_valid;
  logic         io_line_ready;
  logic         io_line_has_data;
  logic         io_line_client_xact_id;
  logic [1:0]   io_line_manager_xact_id;
  logic [511:0] io_line_data;
  logic         io_busy;
  logic         io_error;

  modport slave (
    input  io_refill_valid,
    output io_refill_ready,
    input  io_refill_bits_addr_beat,
    input  io_refill_bits_client_xact_id,
    input  io_refill_bits_manager_xact_id,
    input  io_refill_bits_is_builtin_type,
    input  io_refill_bits_g_type,
    input  io_refill_bits_data,
    output io_line_valid,
    input  io_line_ready,
    output io_line_has_data,
    output io_line_client_xact_id,
    output io_line_manager_xact_id,
    output io_line_data,
    output io_busy,
    output io_error
  );

  modport master (
    output io_refill_valid,
    input  io_refill_ready,
    output io_refill_bits_addr_beat,
    output io_refill_bits_client_xact_id,
    output io_refill_bits_manager_xact_id,
    output io_refill_bits_is_builtin_type,
    output io_refill_bits_g_type,
    output io_refill_bits_data,
    input  io_line_valid,
    output io_line_ready,
    input  io_line_has_data,
    input  io_line_client_xact_id,
    input  io_line_manager_xact_id,
    input  io_line_data,
    input  io_busy,
    input  io_error
  );
endinterface

// File: rtl/coreriscv_axi4_refill_collector.sv
// rtl/coreriscv_axi4_refill_collector.sv - assembles 8x64-bit refill beats into a 512-bit cache line
//
// Purpose: collects refill beats from the grant finish unit into one 512-bit
// line (beat k in bits [64k+63:64k]) and hands it, with the transaction ids
// captured from the first beat, to the data-array writer. Single-beat acks
// pass through as a data-less line (io_line_has_data = 0).
// Ports:
//   clk      clock, all state updated on the rising edge
//   reset_n  synchronous active-low reset
//   bus      collector side (slave modport) of the refill/line bundle
// Build option:
//   CORERISCV_AXI4_REFILL_ORDER_CHECK_EN - when defined, beats are placed by
//   the internal beat counter and any addr_beat mismatch or interleaved ack
//   raises the sticky io_error; otherwise beats land in slot addr_beat and
//   io_error is tied low.
module coreriscv_axi4_refill_collector (
  input  logic clk,
  input  logic reset_n,
  coreriscv_axi4_refill_collector_if.slave bus
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [511:0] line_q, line_d;
  logic         cid_q, cid_d;
  logic [1:0]   mid_q, mid_d;
  logic         has_data_q, has_data_d;
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
  logic         error_q, error_d;
`endif

  logic         accept;
  logic         multibeat;
  logic [2:0]   slot;

  always_comb begin
    accept    = (state_q == ST_FILL) && bus.io_refill_valid;
    multibeat = bus.io_refill_bits_is_builtin_type ? (bus.io_refill_bits_g_type == 4'h5)
                                                   : (bus.io_refill_bits_g_type == 4'h0);
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
    slot = cnt_q;
`else
    slot = bus.io_refill_bits_addr_beat;
`endif

    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    cid_d      = cid_q;
    mid_d      = mid_q;
    has_data_d = has_data_q;
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
    error_d    = error_q;
`endif

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (multibeat) begin
            line_d[{slot, 6'd0} +: 64] = bus.io_refill_bits_data;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd0) begin
              cid_d = bus.io_refill_bits_client_xact_id;
              mid_d = bus.io_refill_bits_manager_xact_id;
            end
            // Completion is decided by the counter, not by addr_beat, so an
            // out-of-order stream still closes after exactly eight beats.
            if (cnt_q == 3'd7) begin
              has_data_d = 1'b1;
              state_d    = ST_HOLD;
            end
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
            if (bus.io_refill_bits_addr_beat != cnt_q) begin
              error_d = 1'b1;
            end
`endif
          end else if (cnt_q == 3'd0) begin
            // Ack line: ids only, the data buffer keeps its previous contents.
            cid_d      = bus.io_refill_bits_client_xact_id;
            mid_d      = bus.io_refill_bits_manager_xact_id;
            has_data_d = 1'b0;
            state_d    = ST_HOLD;
          end else begin
            // Ack interleaved with a partial line is consumed and dropped.
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
            error_d = 1'b1;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (bus.io_line_ready) begin
          state_d = ST_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_FILL;
      cnt_q      <= 3'd0;
      line_q     <= '0;
      cid_q      <= 1'b0;
      mid_q      <= 2'd0;
      has_data_q <= 1'b0;
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      cid_q      <= cid_d;
      mid_q      <= mid_d;
      has_data_q <= has_data_d;
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
      error_q    <= error_d;
`endif
    end
  end

  assign bus.io_refill_ready         = (state_q == ST_FILL);
  assign bus.io_line_valid           = (state_q == ST_HOLD);
  assign bus.io_busy                 = (state_q == ST_FILL) && (cnt_q != 3'd0);
  assign bus.io_line_has_data        = has_data_q;
  assign bus.io_line_client_xact_id  = cid_q;
  assign bus.io_line_manager_xact_id = mid_q;
  assign bus.io_line_data            = line_q;
`ifdef CORERISCV_AXI4_REFILL_ORDER_CHECK_EN
  assign bus.io_error                = error_q;
`else
  assign bus.io_error                = 1'b0;
`endif

endmodule
